// File: rtl/tinyriscv_pkg.sv
// Shared pipeline-control types: hold levels driven to pc_reg/if_id/id_ex and
// the sequencer state encoding.
package tinyriscv_pkg;

    localparam int Hold_Flag_Bus = 3;

    localparam logic [Hold_Flag_Bus-1:0] Hold_None = 3'd0;
    localparam logic [Hold_Flag_Bus-1:0] Hold_Pc   = 3'd1;
    localparam logic [Hold_Flag_Bus-1:0] Hold_If   = 3'd2;
    localparam logic [Hold_Flag_Bus-1:0] Hold_Id   = 3'd3;

    typedef enum logic [1:0] {
        RUN,
        FLUSH,
        HALT_DRAIN,
        HALTED
    } pipe_ctrl_state_e;

endpackage

// File: rtl/pipe_hold_ctrl_if.sv
// Request/response bundle between the core's stall sources and the pipeline
// sequencer; master drives requests, slave (the sequencer) drives hold/jump/ack.
interface pipe_hold_ctrl_if #(
    parameter int CNT_W = 32
);
    logic                                    jump_flag_i;
    logic [31:0]                             jump_addr_i;
    logic                                    hold_ex_i;
    logic                                    hold_bus_i;
    logic                                    clint_hold_i;
    logic                                    jtag_halt_req_i;
    logic                                    jtag_resume_i;
    logic                                    stall_cnt_clr_i;
    logic [tinyriscv_pkg::Hold_Flag_Bus-1:0] hold_flag_o;
    logic                                    jump_flag_o;
    logic [31:0]                             jump_addr_o;
    logic                                    halt_ack_o;
    logic [CNT_W-1:0]                        stall_cnt_o;

    modport master (
        output jump_flag_i, jump_addr_i, hold_ex_i, hold_bus_i, clint_hold_i,
               jtag_halt_req_i, jtag_resume_i, stall_cnt_clr_i,
        input  hold_flag_o, jump_flag_o, jump_addr_o, halt_ack_o, stall_cnt_o
    );

    modport slave (
        input  jump_flag_i, jump_addr_i, hold_ex_i, hold_bus_i, clint_hold_i,
               jtag_halt_req_i, jtag_resume_i, stall_cnt_clr_i,
        output hold_flag_o, jump_flag_o, jump_addr_o, halt_ack_o, stall_cnt_o
    );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Latency: count visible one cycle after the increment/clear cycle.
// Backpressure: none; holds at all-ones, clear wins over increment.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_o <= '0;
        end else if (clr_i) begin
            cnt_o <= '0;
        end else if (inc_i && (cnt_o != '1)) begin
            cnt_o <= cnt_o + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_hold_ctrl.sv
// Merges stall/flush/debug requests into hold_flag and sequences flush and JTAG halt.
// Latency: hold_flag and jump forward are combinational; FSM and halt_ack are registered.
// Backpressure: none; requests are levels/pulses sampled every cycle.
module pipe_hold_ctrl
    import tinyriscv_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int DRAIN_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input logic              clk_i,
    input logic              rst_ni,
    pipe_hold_ctrl_if.slave  bus
);

    localparam bit         FLUSH_EN   = (FLUSH_CYCLES > 1);
    localparam logic [3:0] FLUSH_LOAD = FLUSH_EN ? 4'(FLUSH_CYCLES - 2) : 4'd0;
    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

    pipe_ctrl_state_e state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             halt_pending_q, halt_pending_d;
    logic             halt_ack_q;
    logic             hold_id, hold_pc;
    logic [Hold_Flag_Bus-1:0] hold_flag;

    always_comb begin
        hold_id = bus.jump_flag_i | bus.hold_ex_i | bus.clint_hold_i
                | (state_q == FLUSH) | (state_q == HALTED);
        hold_pc = bus.hold_bus_i | (state_q == HALT_DRAIN);
        if (hold_id) begin
            hold_flag = Hold_Id;
        end else if (hold_pc) begin
            hold_flag = Hold_Pc;
        end else begin
            hold_flag = Hold_None;
        end
    end

    assign bus.hold_flag_o = hold_flag;
    assign bus.jump_flag_o = bus.jump_flag_i;
    assign bus.jump_addr_o = bus.jump_flag_i ? bus.jump_addr_i : 32'd0;
    assign bus.halt_ack_o  = halt_ack_q;

    // One down-counter serves both FLUSH and HALT_DRAIN since they never overlap.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            RUN: begin
                if (bus.jump_flag_i) begin
                    if (FLUSH_EN) begin
                        state_d = FLUSH;
                        cnt_d   = FLUSH_LOAD;
                    end
                end else if (halt_pending_q || bus.jtag_halt_req_i) begin
                    state_d = HALT_DRAIN;
                    cnt_d   = DRAIN_LOAD;
                end
            end
            FLUSH: begin
                if (bus.jump_flag_i) begin
                    cnt_d = FLUSH_LOAD;
                end else if (cnt_q == 4'd0) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            HALT_DRAIN: begin
                // A multi-cycle op in execute freezes the drain until it completes.
                if (!bus.hold_ex_i) begin
                    if (cnt_q == 4'd0) begin
                        state_d = HALTED;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            end
            HALTED: begin
                if (bus.jtag_resume_i) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        halt_pending_d = halt_pending_q;
        if ((state_d == HALTED) && (state_q != HALTED)) begin
            halt_pending_d = 1'b0;
        end else if (bus.jtag_halt_req_i && (state_q != HALTED)) begin
            halt_pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= RUN;
            cnt_q          <= 4'd0;
            halt_pending_q <= 1'b0;
            halt_ack_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            halt_pending_q <= halt_pending_d;
            halt_ack_q     <= (state_d == HALTED);
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (bus.stall_cnt_clr_i),
        .inc_i  (hold_flag != Hold_None),
        .cnt_o  (bus.stall_cnt_o)
    );

endmodule
